// File: rtl/pdp_mem_arbiter_if.sv
// Request/grant/return bundle between the PDP-8 requesters, the memory
// arbiter and the single-port memory.
interface pdp_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 12
);
    logic                  ifu_rd_req;
    logic [ADDR_WIDTH-1:0] ifu_rd_addr;
    logic                  ifu_rd_gnt;
    logic                  ifu_rd_valid;
    logic [DATA_WIDTH-1:0] ifu_rd_data;

    logic                  exec_rd_req;
    logic [ADDR_WIDTH-1:0] exec_rd_addr;
    logic                  exec_rd_gnt;
    logic                  exec_rd_valid;
    logic [DATA_WIDTH-1:0] exec_rd_data;

    logic                  exec_wr_req;
    logic [ADDR_WIDTH-1:0] exec_wr_addr;
    logic [DATA_WIDTH-1:0] exec_wr_data;
    logic                  exec_wr_gnt;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic [15:0]           ifu_wait_cnt;

    // Arbiter side.
    modport slave (
        input  ifu_rd_req, ifu_rd_addr,
        output ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
        input  exec_rd_req, exec_rd_addr,
        output exec_rd_gnt, exec_rd_valid, exec_rd_data,
        input  exec_wr_req, exec_wr_addr, exec_wr_data,
        output exec_wr_gnt,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output ifu_wait_cnt
    );

    // Requester / memory side.
    modport master (
        output ifu_rd_req, ifu_rd_addr,
        input  ifu_rd_gnt, ifu_rd_valid, ifu_rd_data,
        output exec_rd_req, exec_rd_addr,
        input  exec_rd_gnt, exec_rd_valid, exec_rd_data,
        output exec_wr_req, exec_wr_addr, exec_wr_data,
        input  exec_wr_gnt,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  ifu_wait_cnt
    );
endinterface

// File: rtl/pdp_mem_arbiter.sv
// Single-port PDP-8 memory arbiter: exec unit has priority over the IFU,
// with a burst limit that forces an IFU grant after MAX_EXEC_BURST exec
// grants in a row while the IFU is waiting. Reads return one cycle later.
module pdp_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 12,
    parameter int unsigned MAX_EXEC_BURST = 4
) (
    input logic              clk,
    input logic              reset_n,
    pdp_mem_arbiter_if.slave bus
);
    localparam int unsigned BW = $clog2(MAX_EXEC_BURST + 1);

    typedef enum logic [0:0] {StExecPri, StIfuForce} state_e;

    state_e                state_q, state_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  pend_q, pend_d;
    logic                  owner_ifu_q, owner_ifu_d;
    logic [DATA_WIDTH-1:0] ifu_data_q, exec_data_q;
    logic [15:0]           wait_q;
    logic                  gnt_ifu, gnt_wr, gnt_rd, exec_any;

    // Arbitration, burst tracking and next state.
    always_comb begin
        gnt_ifu  = 1'b0;
        gnt_wr   = 1'b0;
        gnt_rd   = 1'b0;
        burst_d  = burst_q;
        exec_any = bus.exec_wr_req | bus.exec_rd_req;
        // Nothing is granted while reset is asserted.
        if (reset_n) begin
            case (state_q)
                StIfuForce: begin
                    if (bus.ifu_rd_req) begin
                        gnt_ifu = 1'b1;
                    end else begin
                        gnt_wr = bus.exec_wr_req;
                        gnt_rd = bus.exec_rd_req & ~bus.exec_wr_req;
                    end
                end
                default: begin
                    if (exec_any) begin
                        gnt_wr = bus.exec_wr_req;
                        gnt_rd = bus.exec_rd_req & ~bus.exec_wr_req;
                    end else begin
                        gnt_ifu = bus.ifu_rd_req;
                    end
                end
            endcase
        end
        if (!bus.ifu_rd_req || gnt_ifu) begin
            burst_d = '0;
        end else if (gnt_wr || gnt_rd) begin
            burst_d = burst_q + BW'(1);
        end
        state_d     = (burst_d == BW'(MAX_EXEC_BURST)) ? StIfuForce : StExecPri;
        pend_d      = gnt_ifu | gnt_rd;
        owner_ifu_d = gnt_ifu;
    end

    // Grants, memory port and read-return outputs.
    always_comb begin
        bus.ifu_rd_gnt    = gnt_ifu;
        bus.exec_wr_gnt   = gnt_wr;
        bus.exec_rd_gnt   = gnt_rd;
        bus.mem_req       = gnt_ifu | gnt_wr | gnt_rd;
        bus.mem_we        = gnt_wr;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        if (gnt_ifu) begin
            bus.mem_addr = bus.ifu_rd_addr;
        end else if (gnt_wr) begin
            bus.mem_addr  = bus.exec_wr_addr;
            bus.mem_wdata = bus.exec_wr_data;
        end else if (gnt_rd) begin
            bus.mem_addr = bus.exec_rd_addr;
        end
        bus.ifu_rd_valid  = pend_q & owner_ifu_q;
        bus.exec_rd_valid = pend_q & ~owner_ifu_q;
        // Pass memory data straight through on the valid cycle, then hold it.
        bus.ifu_rd_data   = bus.ifu_rd_valid ? bus.mem_rdata : ifu_data_q;
        bus.exec_rd_data  = bus.exec_rd_valid ? bus.mem_rdata : exec_data_q;
        bus.ifu_wait_cnt  = wait_q;
    end

    // State, return tag, held read data and IFU wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StExecPri;
            burst_q     <= '0;
            pend_q      <= 1'b0;
            owner_ifu_q <= 1'b0;
            ifu_data_q  <= '0;
            exec_data_q <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            pend_q      <= pend_d;
            owner_ifu_q <= owner_ifu_d;
            if (bus.ifu_rd_valid) begin
                ifu_data_q <= bus.mem_rdata;
            end
            if (bus.exec_rd_valid) begin
                exec_data_q <= bus.mem_rdata;
            end
            if (bus.ifu_rd_req && !gnt_ifu && wait_q != 16'hFFFF) begin
                wait_q <= wait_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Randomized and directed bench for pdp_mem_arbiter against a rule-level
// reference model (priority rules, burst allowance, reference memory).
module tb_pdp_mem_arbiter;
    localparam int AW   = 12;
    localparam int DW   = 12;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pdp_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    pdp_mem_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .MAX_EXEC_BURST(MAXB)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // Memory the arbiter talks to.
    logic [DW-1:0] mem [0:4095] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_req && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:4095] = '{default: '0};
    int            consec;     // exec grants in a row while IFU waited
    bit            pend, pend_ifu;
    logic [DW-1:0] pend_data, hold_ifu, hold_exec;
    int            wait_m;
    bit            hold_reqs;
    logic [2:0]    obs_g;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        consec = 0; pend = 0; pend_ifu = 0; pend_data = '0;
        hold_ifu = '0; hold_exec = '0; wait_m = 0;
    endtask

    // Reset while possibly mid-transaction; outputs must be quiet.
    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        check_eq("rst_gnt", 32'({bus.ifu_rd_gnt, bus.exec_wr_gnt, bus.exec_rd_gnt}), 0);
        check_eq("rst_mem_req", 32'(bus.mem_req), 0);
        check_eq("rst_valid", 32'({bus.ifu_rd_valid, bus.exec_rd_valid}), 0);
        check_eq("rst_ifu_data", 32'(bus.ifu_rd_data), 0);
        check_eq("rst_exec_data", 32'(bus.exec_rd_data), 0);
        check_eq("rst_wait", 32'(bus.ifu_wait_cnt), 0);
        bus.ifu_rd_req = 0; bus.exec_rd_req = 0; bus.exec_wr_req = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One clock: check this cycle's outputs against the model, then advance.
    task automatic step();
        logic [2:0]    eg;
        logic [AW-1:0] ea;
        logic          ex, ifu_win;
        @(negedge clk);
        ex      = bus.exec_wr_req | bus.exec_rd_req;
        ifu_win = bus.ifu_rd_req && (!ex || consec >= MAXB);
        eg = ifu_win ? 3'b100 : bus.exec_wr_req ? 3'b010 : bus.exec_rd_req ? 3'b001 : 3'b000;
        ea = eg[2] ? bus.ifu_rd_addr : eg[1] ? bus.exec_wr_addr :
             eg[0] ? bus.exec_rd_addr : '0;
        obs_g = {bus.ifu_rd_gnt, bus.exec_wr_gnt, bus.exec_rd_gnt};
        check_eq("gnt", 32'(obs_g), 32'(eg));
        check_eq("mem_req", 32'(bus.mem_req), 32'(eg != 3'b000));
        check_eq("mem_we", 32'(bus.mem_we), 32'(eg[1]));
        check_eq("mem_addr", 32'(bus.mem_addr), 32'(ea));
        if (eg[1]) check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(bus.exec_wr_data));
        check_eq("ifu_valid", 32'(bus.ifu_rd_valid), 32'(pend && pend_ifu));
        check_eq("exec_valid", 32'(bus.exec_rd_valid), 32'(pend && !pend_ifu));
        if (pend && pend_ifu) hold_ifu = pend_data;
        if (pend && !pend_ifu) hold_exec = pend_data;
        check_eq("ifu_data", 32'(bus.ifu_rd_data), 32'(hold_ifu));
        check_eq("exec_data", 32'(bus.exec_rd_data), 32'(hold_exec));
        check_eq("wait_cnt", 32'(bus.ifu_wait_cnt), 32'(wait_m));
        // Advance model by the rules.
        pend      = eg[2] | eg[0];
        pend_ifu  = eg[2];
        pend_data = eg[2] ? ref_mem[bus.ifu_rd_addr] : ref_mem[bus.exec_rd_addr];
        if (eg[1]) ref_mem[bus.exec_wr_addr] = bus.exec_wr_data;
        if (bus.ifu_rd_req && !eg[2] && wait_m < 65535) wait_m++;
        if ((eg[1] || eg[0]) && bus.ifu_rd_req) consec++;
        else consec = 0;
        @(posedge clk);
        #1;
        if (!hold_reqs) begin
            if (eg[2]) bus.ifu_rd_req = 0;
            if (eg[1]) bus.exec_wr_req = 0;
            if (eg[0]) bus.exec_rd_req = 0;
        end
    endtask

    logic [2:0] pat [10];

    initial begin
        bus.ifu_rd_req = 0; bus.exec_rd_req = 0; bus.exec_wr_req = 0;
        bus.ifu_rd_addr = '0; bus.exec_rd_addr = '0; bus.exec_wr_addr = '0;
        bus.exec_wr_data = '0;
        hold_reqs = 0;
        model_clear();
        do_reset();

        // Seed mem[0200] = 7001 through the exec write path, then IFU-only read.
        bus.exec_wr_req = 1; bus.exec_wr_addr = 12'o0200; bus.exec_wr_data = 12'o7001;
        step();
        bus.ifu_rd_req = 1; bus.ifu_rd_addr = 12'o0200;
        step();
        step();
        check_eq("ifu_only_hold", 32'(bus.ifu_rd_data), 32'(12'o7001));

        // Conflict: exec write first, IFU next cycle, one wait cycle.
        do_reset();
        bus.ifu_rd_req = 1; bus.ifu_rd_addr = 12'o0200;
        bus.exec_wr_req = 1; bus.exec_wr_addr = 12'o0300; bus.exec_wr_data = 12'o1234;
        step();
        check_eq("conflict_first", 32'(obs_g), 32'(3'b010));
        step();
        check_eq("conflict_second", 32'(obs_g), 32'(3'b100));
        check_eq("conflict_wait", 32'(bus.ifu_wait_cnt), 1);
        step();

        // Exec write and read of the same address together.
        do_reset();
        bus.exec_wr_req = 1; bus.exec_wr_addr = 12'o0050; bus.exec_wr_data = 12'o0777;
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o0050;
        step();
        step();
        step();
        check_eq("wr_then_rd", 32'(bus.exec_rd_data), 32'(12'o0777));

        // Starvation guard: E,E,E,E,I repeating.
        do_reset();
        pat = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100,
                3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
        hold_reqs = 1;
        bus.ifu_rd_req = 1; bus.ifu_rd_addr = 12'o0200;
        bus.exec_rd_req = 1; bus.exec_rd_addr = 12'o0300;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("starve_pattern", 32'(obs_g), 32'(pat[i]));
        end
        hold_reqs = 0;
        bus.ifu_rd_req = 0; bus.exec_rd_req = 0;
        step();

        // Alternating IFU / exec reads.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                bus.ifu_rd_req = 1; bus.ifu_rd_addr = (i == 0) ? 12'o0200 : 12'o0300;
            end else begin
                bus.exec_rd_req = 1; bus.exec_rd_addr = (i == 1) ? 12'o0050 : 12'o0200;
            end
            step();
        end
        step();

        // Reset in the cycle after a read grant: the return is dropped.
        bus.ifu_rd_req = 1; bus.ifu_rd_addr = 12'o0200;
        hold_reqs = 1;
        step();
        hold_reqs = 0;
        do_reset();
        step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (!bus.ifu_rd_req && $urandom_range(1, 0) == 1) begin
                bus.ifu_rd_req = 1; bus.ifu_rd_addr = 12'($urandom_range(31, 0));
            end
            if (!bus.exec_rd_req && $urandom_range(2, 0) == 0) begin
                bus.exec_rd_req = 1; bus.exec_rd_addr = 12'($urandom_range(31, 0));
            end
            if (!bus.exec_wr_req && $urandom_range(2, 0) == 0) begin
                bus.exec_wr_req = 1; bus.exec_wr_addr = 12'($urandom_range(31, 0));
                bus.exec_wr_data = 12'($urandom);
            end
            step();
        end
        bus.ifu_rd_req = 0; bus.exec_rd_req = 0; bus.exec_wr_req = 0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
